conv_window_gen: RTL and testbench

- Downstream of the image loader. Consumes a loaded image as a row-major pixel stream.
- Produces every KxK convolution window, valid-only with stride 1, for the CNN convolution datapath.
- Buffers K-1 image rows in line buffers, plus a KxK window register array.
- Uses valid/ready handshakes on both sides, with full backpressure.

---
 rtl/cnn_pkg.sv | 8 +
 rtl/conv_window_gen_line_buffer.sv | 21 ++
 rtl/conv_window_gen.sv | 100 ++++++++++
 tb/tb_conv_window_gen.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared pixel type, CNN sizing constants and window-generator state encoding
package cnn_pkg;
  localparam int DATA_SIZE = 16;
  localparam int MAX_IMG_SIZE = 32;
  localparam int CONV_K = 5;
  typedef logic [DATA_SIZE-1:0] pixel_t;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} win_state_t;
endpackage

// File: rtl/conv_window_gen_line_buffer.sv
// line_buffer: one image row of storage, read-before-write at a shared column address
module line_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  assign rd_data = mem[addr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    else if (we)
      mem[addr] <= wr_data;
endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: stride-1 KxK valid-window generator over a row-major pixel stream (CONV_WINDOW_STRIDE2_EN selects stride 2)
module conv_window_gen
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_SIZE,
  parameter int MAX_IMG = MAX_IMG_SIZE,
  parameter int K = CONV_K
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [5:0]                imgSize,
  input  logic [DATA_WIDTH-1:0]     pixIn,
  input  logic                      pixValid,
  output logic                      pixReady,
  output logic [K*K*DATA_WIDTH-1:0] window,
  output logic                      winValid,
  input  logic                      winReady,
  output logic                      busy,
  output logic                      done
);
  localparam int AW = $clog2(MAX_IMG);
  localparam logic [5:0] KM1 = 6'(K - 1);
  win_state_t state, state_nx;
  logic [5:0] n, row, col;
  logic accept, last, emit, phase_ok;
  logic [DATA_WIDTH-1:0] lb_wr [K-1];
  logic [DATA_WIDTH-1:0] lb_rd [K-1];
  logic [DATA_WIDTH-1:0] new_col [K];
  logic [DATA_WIDTH-1:0] win [K][K];
`ifdef CONV_WINDOW_STRIDE2_EN
  assign phase_ok = (row[0] == KM1[0]) && (col[0] == KM1[0]);
`else
  assign phase_ok = 1'b1;
`endif
  always_comb begin
    pixReady = (state == RUN) && !(winValid && !winReady);
    accept = pixValid && pixReady;
    last = (row == n - 6'd1) && (col == n - 6'd1);
    emit = accept && (row >= KM1) && (col >= KM1) && phase_ok;
    busy = state != IDLE;
    done = (state == FLUSH) && !winValid;
    state_nx = (state == IDLE && start) ? RUN :
               (state == RUN && accept && last) ? FLUSH :
               done ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      n <= '0;
      row <= '0;
      col <= '0;
      winValid <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        n <= (imgSize == 6'd0 || imgSize > 6'(MAX_IMG)) ? 6'(MAX_IMG) : imgSize;
        row <= '0;
        col <= '0;
      end else if (accept) begin
        col <= (col == n - 6'd1) ? 6'd0 : col + 6'd1;
        row <= (col == n - 6'd1) ? row + 6'd1 : row;
      end
      winValid <= emit || (winValid && !winReady);
    end
  assign lb_wr[0] = pixIn;
  for (genvar i = 1; i < K - 1; i++) begin : g_chain
    assign lb_wr[i] = lb_rd[i-1];
  end
  for (genvar i = 0; i < K - 1; i++) begin : g_lb
    line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(MAX_IMG)) u_lb (
      .clk(clk),
      .rst_n(rst_n),
      .we(accept),
      .addr(col[AW-1:0]),
      .wr_data(lb_wr[i]),
      .rd_data(lb_rd[i])
    );
  end
  for (genvar r = 0; r < K - 1; r++) begin : g_col
    assign new_col[r] = lb_rd[K-2-r];
  end
  assign new_col[K-1] = pixIn;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) win[r][c] <= '0;
    end else if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) win[r][c] <= win[r][c+1];
        win[r][K-1] <= new_col[r];
      end
    end
  for (genvar r = 0; r < K; r++) begin : g_row
    for (genvar c = 0; c < K; c++) begin : g_el
      assign window[(r*K+c)*DATA_WIDTH +: DATA_WIDTH] = win[r][c];
    end
  end
endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: directed frames checked against an image-indexing window model
module tb_conv_window_gen;
  import cnn_pkg::*;
  localparam int DW = DATA_SIZE;
  localparam int K = CONV_K;
  localparam int MAXN = MAX_IMG_SIZE;
`ifdef CONV_WINDOW_STRIDE2_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif
  logic clk = 0, rst_n = 0, start = 0, pixValid = 0, winReady = 0;
  logic pixReady, winValid, busy, done;
  logic [5:0] imgSize = '0;
  logic [DW-1:0] pixIn = '0;
  logic [K*K*DW-1:0] window;
  int checks = 0, errors = 0;
  int cur_n = 1, cur_base = 0, exp_cnt = 0, got = 0, done_cnt = 0;
  int cyc = 0, first_valid_cyc = -1, acc132 = -1;
  bit mon_on = 0;
  bit prev_stall = 0;
  logic [K*K*DW-1:0] prev_win, first_win, last_win;
  logic [DW-1:0] log00 [$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  conv_window_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .imgSize(imgSize),
    .pixIn(pixIn), .pixValid(pixValid), .pixReady(pixReady),
    .window(window), .winValid(winValid), .winReady(winReady),
    .busy(busy), .done(done)
  );
  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask
  task automatic chk_win(input string name, input logic [K*K*DW-1:0] act, input logic [K*K*DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  function automatic int per_row(input int n);
    return n < K ? 0 : (n - K + S) / S;
  endfunction
  function automatic logic [K*K*DW-1:0] exp_win(input int w);
    int m = per_row(cur_n);
    int r0 = (w / m) * S;
    int c0 = (w % m) * S;
    logic [K*K*DW-1:0] v = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        v[(r*K+c)*DW +: DW] = DW'(cur_base + (r0 + r) * cur_n + c0 + c);
    return v;
  endfunction
  always @(negedge clk) begin
    #2;
    if (mon_on && rst_n) begin
      if (prev_stall) begin
        chk("stall_valid_held", winValid, 1);
        chk_win("stall_window_stable", window, prev_win);
      end
      if (winValid && !winReady) chk("stall_pixready_low", pixReady, 0);
      if (winValid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (winValid && winReady) begin
        if (got < exp_cnt) chk_win("window", window, exp_win(got));
        else chk("window_extra", got + 1, exp_cnt);
        if (got == 0) first_win = window;
        last_win = window;
        log00.push_back(window[DW-1:0]);
        got++;
      end
      if (done) begin
        done_cnt++;
        chk("done_after_all_windows", got, exp_cnt);
      end
      prev_stall = winValid && !winReady;
      prev_win = window;
    end else prev_stall = 0;
  end
  task automatic run_frame(input int n_img, input int base, input int mode, input int abort_at);
    int n_eff = (n_img == 0 || n_img > MAXN) ? MAXN : n_img;
    int total = n_eff * n_eff;
    int idx = 0;
    int t = 0;
    cur_n = n_eff;
    cur_base = base;
    exp_cnt = per_row(n_eff) * per_row(n_eff);
    got = 0;
    done_cnt = 0;
    first_valid_cyc = -1;
    acc132 = -1;
    log00.delete();
    mon_on = 1;
    @(negedge clk);
    start = 1;
    imgSize = 6'(n_img);
    winReady = 1;
    @(negedge clk);
    start = 0;
    #1 chk("busy_after_start", busy, 1);
    while (idx < total && t < 20000 && !(abort_at > 0 && idx == abort_at)) begin
      @(negedge clk);
      t++;
      winReady = (mode == 0) || (t % 3 == 0);
      pixValid = 1;
      pixIn = DW'(base + idx);
      #1;
      if (pixReady) begin
        if (idx == 132) acc132 = cyc + 1;
        idx++;
      end
    end
    if (abort_at > 0) begin
      @(negedge clk);
      pixValid = 0;
      rst_n = 0;
      #1;
      chk("abort_pixready", pixReady, 0);
      chk("abort_winvalid", winValid, 0);
      chk("abort_window_zero", window == '0, 1);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      repeat (2) @(negedge clk);
      rst_n = 1;
      repeat (3) @(negedge clk);
      #3 chk("abort_no_done", done_cnt, 0);
      chk("abort_idle", busy, 0);
      return;
    end
    while (done_cnt == 0 && t < 20000) begin
      @(negedge clk);
      t++;
      pixValid = 0;
      winReady = (mode == 0) || (t % 3 == 0);
      #3;
    end
    chk("frame_done_seen", done_cnt > 0, 1);
    repeat (4) @(negedge clk) winReady = 1;
    #3;
    chk("pixels_accepted", idx, total);
    chk("done_once", done_cnt, 1);
    chk("window_count", got, exp_cnt);
    chk("idle_after_done", busy, 0);
  endtask
  initial begin
    #1;
    chk("rst_pixready", pixReady, 0);
    chk("rst_winvalid", winValid, 0);
    chk("rst_window", window == '0, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    pixValid = 1;
    repeat (3) begin
      @(negedge clk);
      #1 chk("idle_pixready", pixReady, 0);
      chk("idle_busy", busy, 0);
    end
    pixValid = 0;
    run_frame(32, 0, 0, 0);
    chk("count_n32", got, S == 1 ? 784 : 196);
`ifdef CONV_WINDOW_STRIDE2_EN
    chk("stride2_w1_00", log00[1], 2);
    chk("stride2_w14_00", log00[14], 64);
`else
    chk("first_valid_latency", first_valid_cyc, acc132);
    chk("first_00", first_win[0 +: DW], 0);
    chk("first_04", first_win[4*DW +: DW], 4);
    chk("first_40", first_win[20*DW +: DW], 128);
    chk("first_44", first_win[24*DW +: DW], 132);
    chk("last_44", last_win[24*DW +: DW], 1023);
    chk("second_00", log00[1], 1);
`endif
    run_frame(32, 0, 1, 0);
    chk("count_n32_stall", got, S == 1 ? 784 : 196);
    run_frame(4, 0, 0, 0);
    chk("count_n4", got, 0);
    run_frame(5, 0, 0, 0);
    chk("count_n5", got, 1);
    chk("n5_00", first_win[0 +: DW], 0);
    chk("n5_44", first_win[24*DW +: DW], 24);
    run_frame(32, 0, 0, 200);
    run_frame(8, 5000, 0, 0);
    chk("count_n8", got, S == 1 ? 16 : 4);
    chk("n8_first_44", first_win[24*DW +: DW], 5036);
    run_frame(0, 100, 0, 0);
    chk("count_n0", got, S == 1 ? 784 : 196);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
